// File: rtl/flow_sender_if.sv
// Word stream, flow-control and lane push signals of flow_sender.
// master is the sender block itself; slave is its surrounding environment.
interface flow_sender_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_dest;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        pausa;
    logic              error_full;
    logic              idle;
    logic [3:0]        push;
    logic [DATA_W-1:0] push_data;

    modport master (
        input  in_data, in_dest, in_valid, pausa, error_full, idle,
        output in_ready, push, push_data
    );

    modport slave (
        output in_data, in_dest, in_valid, pausa, error_full, idle,
        input  in_ready, push, push_data
    );
endinterface

// File: rtl/flow_sender.sv
// Upstream write side of the 4-lane FIFO flow control: one-entry hold, lane push, pause/halt FSM.
// Define FLOW_SENDER_STATS_EN to add the stall_cnt port counting cycles spent paused.
module flow_sender #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    flow_sender_if.master    bus,
    output logic             halted,
    output logic [CNT_W-1:0] sent_cnt
`ifdef FLOW_SENDER_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StWait,
        StRun,
        StPaused,
        StHalt
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] hold_data_q;
    logic [1:0]        hold_dest_q;
    logic              hold_valid_q;
    logic [CNT_W-1:0]  sent_cnt_q;

    logic lane_paused;
    logic fire;
    logic ready;
    logic accept;

    // Only the lane of the held word matters; pauses on other lanes do not block it.
    assign lane_paused = bus.pausa[hold_dest_q];

    // rst gates everything combinational so nothing escapes during the reset cycle.
    assign fire   = !rst && hold_valid_q && (state_q == StRun) && !lane_paused && !bus.error_full;
    assign ready  = !rst && ((state_q == StRun) || (state_q == StPaused)) && (!hold_valid_q || fire);
    assign accept = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.push_data = rst ? '0 : hold_data_q;
    assign halted        = !rst && (state_q == StHalt);
    assign sent_cnt      = sent_cnt_q;

    always_comb begin
        bus.push = '0;
        if (fire) begin
            bus.push[hold_dest_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWait: begin
                if (bus.idle) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.error_full) begin
                    state_d = StHalt;
                end else if (hold_valid_q && lane_paused) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (bus.error_full) begin
                    state_d = StHalt;
                end else if (!lane_paused) begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept has priority over the clear so a same-cycle fire+accept refills the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_dest_q  <= '0;
        end else if (accept) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= bus.in_data;
            hold_dest_q  <= bus.in_dest;
        end else if (fire) begin
            hold_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt_q <= '0;
        end else if (fire && (sent_cnt_q != '1)) begin
            sent_cnt_q <= sent_cnt_q + CNT_W'(1);
        end
    end

`ifdef FLOW_SENDER_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StPaused) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
